// File: rtl/opc_intc_if.sv
// opc_intc_if -- CPU-side bus of the OPC interrupt controller.
//   vio      IO-cycle qualifier          rnw      1 = read, 0 = write
//   address  CPU address                 din      CPU write data
//   dout     read data (combinational)   int_req  registered interrupt request
//   vector   registered vector           ack      one-clken-cycle take pulse
// slave  : the controller side.  master : the CPU side.
interface opc_intc_if #(
    parameter int DW = 16
) ();
    logic          vio;
    logic          rnw;
    logic [DW-1:0] address;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          int_req;
    logic [DW-1:0] vector;
    logic          ack;

    modport slave  (input  vio, rnw, address, din, ack,
                    output dout, int_req, vector);
    modport master (output vio, rnw, address, din, ack,
                    input  dout, int_req, vector);
endinterface

// File: rtl/opc_intc.sv
// opc_intc -- prioritised, vectored interrupt controller for the OPC CPU.
// Channel 0 is the highest priority. Four IO registers at IO_BASE..IO_BASE+3:
//   0 PEND (read pending / write-1-clear edge pending), 1 MASK, 2 EDGE,
//   3 STAT (read {int_req, id[11:8], isr}; any write is an EOI).
// Ports:
//   clk      system clock
//   reset_b  asynchronous active-low reset
//   clken    clock enable for every state update
//   irq_b    NCHAN active-low request lines, asynchronous to clk
//   bus      opc_intc_if.slave (vio, rnw, address, din, dout, int_req, vector, ack)
// Build option: define OPC_INTC_NEST_EN for priority-nested servicing; the
// default build is single-level (any in-service bit blocks all candidates).

// Per-channel front end: two-flop synchroniser, falling-edge latch, pending.
module opc_intc_chan (
    input  logic clk,
    input  logic reset_b,
    input  logic clken,
    input  logic irq_b,
    input  logic edge_mode,
    input  logic clr,
    output logic pend
);
    logic s1, s2, s3, edge_pend;

    // Sync flops reset to the inactive (high) level so reset release never
    // looks like a falling edge.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            edge_pend <= 1'b0;
        end else if (clken) begin
            s1 <= irq_b;
            s2 <= s1;
            s3 <= s2;
            // A new edge beats a same-cycle clear.
            if (s3 && !s2 && edge_mode)
                edge_pend <= 1'b1;
            else if (clr)
                edge_pend <= 1'b0;
        end
    end

    assign pend = edge_mode ? edge_pend : ~s2;
endmodule

module opc_intc #(
    parameter int            NCHAN      = 8,
    parameter int            DW         = 16,
    parameter logic [DW-1:0] IO_BASE    = 16'hFE00,
    parameter logic [DW-1:0] VEC_BASE   = 16'h0002,
    parameter int            VEC_STRIDE = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             clken,
    input  logic [NCHAN-1:0] irq_b,
    opc_intc_if.slave        bus
);
    localparam int IDW = 4;

    typedef enum logic {IDLE, REQ} state_t;

    state_t           state, state_n;
    logic [NCHAN-1:0] mask_r, edge_r, isr, isr_n, isr_lo, allowed;
    logic [NCHAN-1:0] pend, req, w1c, chan_clr, id_oh;
    logic [IDW-1:0]   id_r, id_n, cand_id;
    logic [DW-1:0]    vector_r, vec_n, cand_vec, off;
    logic             int_req_r, int_req_n, cand_vld, ack_take;
    logic             sel, wr, rd, eoi;

    // ---------------- register decode ----------------
    assign off = bus.address - IO_BASE;
    assign sel = bus.vio && (off < DW'(4));
    assign wr  = clken && sel && !bus.rnw;
    assign rd  = sel && bus.rnw;
    assign w1c = (wr && off[1:0] == 2'd0) ? bus.din[NCHAN-1:0] : '0;
    assign eoi = wr && off[1:0] == 2'd3;

    // ---------------- channel front ends ----------------
    assign id_oh    = NCHAN'(1) << id_r;
    assign chan_clr = w1c | (ack_take ? id_oh : '0);

    opc_intc_chan u_chan [NCHAN-1:0] (
        .clk       (clk),
        .reset_b   (reset_b),
        .clken     (clken),
        .irq_b     (irq_b),
        .edge_mode (edge_r),
        .clr       (chan_clr),
        .pend      (pend)
    );

    // ---------------- priority ----------------
    // isr_lo isolates the highest-priority in-service bit.
    assign isr_lo = isr & (~isr + NCHAN'(1));
`ifdef OPC_INTC_NEST_EN
    // Only channels strictly above the active service level may interrupt.
    assign allowed = (isr == '0) ? '1 : (isr_lo - NCHAN'(1));
`else
    assign allowed = (isr == '0) ? '1 : '0;
`endif
    assign req = pend & mask_r & allowed;

    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (req[i]) begin
                cand_vld = 1'b1;
                cand_id  = IDW'(i);
            end
        end
    end

    assign cand_vec = VEC_BASE + DW'(cand_id) * DW'(VEC_STRIDE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            state <= IDLE;
        else if (clken)
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        int_req_n = int_req_r;
        vec_n     = vector_r;
        id_n      = id_r;
        ack_take  = 1'b0;
        case (state)
            IDLE: begin
                if (cand_vld) begin
                    state_n   = REQ;
                    int_req_n = 1'b1;
                    vec_n     = cand_vec;
                    id_n      = cand_id;
                end
            end
            REQ: begin
                // Locked: ack wins over a same-cycle MASK write; otherwise
                // withdraw once the locked channel is no longer live.
                if (bus.ack) begin
                    ack_take  = 1'b1;
                    state_n   = IDLE;
                    int_req_n = 1'b0;
                end else if ((pend & mask_r & id_oh) == '0) begin
                    state_n   = IDLE;
                    int_req_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // EOI retires against the pre-ack ISR, then ack sets its bit.
    assign isr_n = (eoi ? (isr & ~isr_lo) : isr) | (ack_take ? id_oh : '0);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            int_req_r <= 1'b0;
            vector_r  <= VEC_BASE;
            id_r      <= '0;
            mask_r    <= '0;
            edge_r    <= '0;
            isr       <= '0;
        end else if (clken) begin
            int_req_r <= int_req_n;
            vector_r  <= vec_n;
            id_r      <= id_n;
            isr       <= isr_n;
            if (wr && off[1:0] == 2'd1) mask_r <= bus.din[NCHAN-1:0];
            if (wr && off[1:0] == 2'd2) edge_r <= bus.din[NCHAN-1:0];
        end
    end

    assign bus.int_req = int_req_r;
    assign bus.vector  = vector_r;

    // ---------------- read mux ----------------
    // For NCHAN > 8 the ISR field overlaps the id/int_req fields; they are ORed.
    always_comb begin
        bus.dout = '0;
        if (rd) begin
            case (off[1:0])
                2'd0:    bus.dout = DW'(pend);
                2'd1:    bus.dout = DW'(mask_r);
                2'd2:    bus.dout = DW'(edge_r);
                default: bus.dout = DW'(isr) | (DW'(id_r) << 8) | (DW'(int_req_r) << 15);
            endcase
        end
    end
endmodule
